// File: rtl/sfq_sync_pulse_counter_pkg.sv
// Shared types and helpers for the SFQ pulse-count monitor.
// Optional feature macro used by the top level: SFQ_ZERO_CHECK_EN.
package sfq_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } mon_state_t;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_WIN_LEN = 16;
  // Saturation value of the default-width pulse counter
  localparam int DEF_SAT_MAX = (32'sd1 <<< DEF_CNT_W) - 32'sd1;

  // Width of the window-position counter
  function automatic int win_w(input int win_len);
    return $clog2(win_len);
  endfunction

endpackage

// File: rtl/sfq_sync_pulse_counter_toggle_detect.sv
// Toggle-encoded pulse detector: every level change on a is one pulse.
// The previous-level register reloads the live level during reset so the
// level present at reset release never shows up as a pulse.
module sfq_toggle_detect (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic pulse
);

  logic a_prev_r;

  // Remember last cycle's level of a (also loaded during reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      a_prev_r <= a;
    end else begin
      a_prev_r <= a;
    end
  end

  assign pulse = a ^ a_prev_r;

endmodule

// File: rtl/sfq_sync_pulse_counter.sv
// Windowed pulse counter for clocked SFQ cell outputs.
// Counts toggle pulses on a over WIN_LEN clk cycles and reports the
// saturating count through a valid/ready handshake.
// Optional macro SFQ_ZERO_CHECK_EN adds expect_zero/err (sticky pulse error).
module sfq_sync_pulse_counter
  import sfq_mon_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             a,
  input  logic             ready,
`ifdef SFQ_ZERO_CHECK_EN
  input  logic             expect_zero,
  output logic             err,
`endif
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             busy
);

  localparam int               WW       = win_w(WIN_LEN);
  localparam logic [WW-1:0]    WIN_LAST = WW'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] SAT_MAX  = {CNT_W{1'b1}};

  mon_state_t       state_r;
  mon_state_t       state_n;
  logic             pulse_s;
  logic             win_last_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             ovf_i_r;
  logic             ovf_nxt_s;
  logic [WW-1:0]    win_r;
  logic [CNT_W-1:0] count_r;
  logic             ovf_r;
  logic             valid_r;

  sfq_toggle_detect u_det (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .pulse (pulse_s)
  );

  assign win_last_s = (win_r == WIN_LAST);

  // Saturating count and overflow flag including this cycle's pulse
  always_comb begin
    cnt_nxt_s = cnt_r;
    ovf_nxt_s = ovf_i_r;
    if (pulse_s && (cnt_r != SAT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else if (pulse_s) begin
      ovf_nxt_s = 1'b1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; valid is high for the whole of REPORT
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_n = COUNT;
        else       state_n = IDLE;
      end
      COUNT: begin
        if (win_last_s) state_n = REPORT;
        else            state_n = COUNT;
      end
      REPORT: begin
        if (ready && cont) state_n = COUNT;
        else if (ready)    state_n = IDLE;
        else               state_n = REPORT;
      end
      default: state_n = IDLE;
    endcase
  end

  // Window datapath and report registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      win_r   <= '0;
      ovf_i_r <= 1'b0;
      count_r <= '0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r   <= '0;
            win_r   <= '0;
            ovf_i_r <= 1'b0;
          end
        end
        COUNT: begin
          cnt_r   <= cnt_nxt_s;
          win_r   <= win_r + WW'(1);
          ovf_i_r <= ovf_nxt_s;
          if (win_last_s) begin
            count_r <= cnt_nxt_s;
            ovf_r   <= ovf_nxt_s;
            valid_r <= 1'b1;
          end
        end
        REPORT: begin
          // Pulses are ignored here; a handshake clears the window for a restart
          if (ready) begin
            valid_r <= 1'b0;
            cnt_r   <= '0;
            win_r   <= '0;
            ovf_i_r <= 1'b0;
          end
        end
        default: begin
          valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef SFQ_ZERO_CHECK_EN
  logic err_r;

  // Sticky error: a pulse was counted while the cell was expected silent
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state_r == COUNT) && pulse_s && expect_zero) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`endif

  // Output decode from the state register
  always_comb begin
    busy = (state_r != IDLE);
  end

  assign valid = valid_r;
  assign count = count_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_sfq_sync_pulse_counter.sv
// Bench for sfq_sync_pulse_counter: two instances (8-bit and 3-bit counts)
// on shared stimulus, a table of whole-window vectors, hand sequences for
// hold/restart/reset corners, and a randomized run against a window model.
module tb_sfq_sync_pulse_counter;

  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       rst, start, cont, a, ready, ez;
  logic       valid8, ovf8, busy8, valid3, ovf3, busy3;
  logic [7:0] count8;
  logic [2:0] count3;
`ifdef SFQ_ZERO_CHECK_EN
  logic       err8, err3;
`endif

  always #5 clk = ~clk;

  sfq_sync_pulse_counter #(.CNT_W(8), .WIN_LEN(WIN)) dut8 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .a(a), .ready(ready),
`ifdef SFQ_ZERO_CHECK_EN
    .expect_zero(ez), .err(err8),
`endif
    .valid(valid8), .count(count8), .ovf(ovf8), .busy(busy8)
  );

  sfq_sync_pulse_counter #(.CNT_W(3), .WIN_LEN(WIN)) dut3 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .a(a), .ready(ready),
`ifdef SFQ_ZERO_CHECK_EN
    .expect_zero(ez), .err(err3),
`endif
    .valid(valid3), .count(count3), .ovf(ovf3), .busy(busy3)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Window-level model: phase, edges left in window, raw toggle total
  int   m_ph   = 0;  // 0 idle, 1 counting, 2 reporting
  int   m_left = 0;
  int   m_tog  = 0;
  int   m_c8   = 0;
  int   m_c3   = 0;
  logic m_a_prev = 1'b0;
  logic m_valid  = 1'b0;
  logic m_ovf8   = 1'b0;
  logic m_ovf3   = 1'b0;
  logic m_err    = 1'b0;
  logic a_lvl    = 1'b1;

  typedef struct {
    logic [15:0] mask;  // bit k: a toggles just before window edge k+1
    int          c8;
    logic        o8;
    int          c3;
    logic        o3;
  } win_vec_t;

  win_vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tot++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
  endtask

  task automatic model_edge(input logic r, input logic s, input logic c,
                            input logic av, input logic rd);
    if (r) begin
      m_ph = 0; m_valid = 1'b0; m_tog = 0;
      m_c8 = 0; m_c3 = 0; m_ovf8 = 1'b0; m_ovf3 = 1'b0; m_err = 1'b0;
    end else begin
      if (m_ph == 1 && av != m_a_prev && ez) m_err = 1'b1;
      case (m_ph)
        0: if (s) begin m_ph = 1; m_left = WIN; m_tog = 0; end
        1: begin
          if (av != m_a_prev) m_tog++;
          m_left--;
          if (m_left == 0) begin
            m_ph    = 2;
            m_valid = 1'b1;
            m_c8    = (m_tog > 255) ? 255 : m_tog;
            m_ovf8  = (m_tog > 255);
            m_c3    = (m_tog > 7) ? 7 : m_tog;
            m_ovf3  = (m_tog > 7);
          end
        end
        default: if (rd) begin
          m_valid = 1'b0;
          if (c) begin m_ph = 1; m_left = WIN; m_tog = 0; end
          else m_ph = 0;
        end
      endcase
    end
    m_a_prev = av;
  endtask

  task automatic compare_all();
    chk("valid8", valid8, m_valid);
    chk("valid3", valid3, m_valid);
    chk("busy8",  busy8,  m_ph != 0);
    chk("busy3",  busy3,  m_ph != 0);
    chk("count8", count8, m_c8);
    chk("count3", count3, m_c3);
    chk("ovf8",   ovf8,   m_ovf8);
    chk("ovf3",   ovf3,   m_ovf3);
`ifdef SFQ_ZERO_CHECK_EN
    chk("err8", err8, m_err);
    chk("err3", err3, m_err);
`endif
  endtask

  task automatic step(input logic r, input logic s, input logic c,
                      input logic av, input logic rd);
    rst = r; start = s; cont = c; a = av; ready = rd;
    @(posedge clk);
    model_edge(r, s, c, av, rd);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; a = 1'b1; ready = 1'b0; ez = 1'b0;

    tbl[0] = '{16'h0000, 0,  1'b0, 0, 1'b0};
    tbl[1] = '{16'h8425, 5,  1'b0, 5, 1'b0};
    tbl[2] = '{16'hFFFF, 16, 1'b0, 7, 1'b1};
    tbl[3] = '{16'h007F, 7,  1'b0, 7, 1'b0};
    tbl[4] = '{16'h00FF, 8,  1'b0, 7, 1'b1};
    tbl[5] = '{16'h0001, 1,  1'b0, 1, 1'b0};

    // Reset with a=1
    step(1'b1, 1'b0, 1'b0, a_lvl, 1'b0);
    step(1'b1, 1'b0, 1'b0, a_lvl, 1'b0);
    chk("rst_valid", valid8, 1'b0);
    chk("rst_count", count8, 8'd0);
    chk("rst_ovf",   ovf8,   1'b0);
    chk("rst_busy",  busy8,  1'b0);

    // Table of whole windows
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, a_lvl, 1'b0);
      chk("tbl_busy_after_start", busy8, 1'b1);
      for (int k = 0; k < WIN; k++) begin
        if (tbl[i].mask[k]) a_lvl = ~a_lvl;
        step(1'b0, 1'b0, 1'b0, a_lvl, 1'b0);
        if (k == WIN - 2) chk("tbl_valid_early", valid8, 1'b0);
      end
      chk("tbl_valid", valid8, 1'b1);
      chk("tbl_count8", count8, tbl[i].c8);
      chk("tbl_ovf8", ovf8, tbl[i].o8);
      chk("tbl_count3", count3, tbl[i].c3);
      chk("tbl_ovf3", ovf3, tbl[i].o3);
      step(1'b0, 1'b0, 1'b0, a_lvl, 1'b1);
      chk("tbl_valid_drop", valid8, 1'b0);
      chk("tbl_idle", busy8, 1'b0);
      chk("tbl_count_held", count8, tbl[i].c8);
    end

    // Hold report with ready low while a toggles, then continuous restart
    step(1'b0, 1'b1, 1'b0, a_lvl, 1'b0);
    for (int k = 0; k < WIN; k++) begin
      if (k < 3) a_lvl = ~a_lvl;
      step(1'b0, 1'b0, 1'b0, a_lvl, 1'b0);
    end
    chk("hold_valid_rise", valid8, 1'b1);
    for (int k = 0; k < 10; k++) begin
      a_lvl = ~a_lvl;
      step(1'b0, 1'b0, 1'b0, a_lvl, 1'b0);
      chk("hold_count", count8, 8'd3);
      chk("hold_valid", valid8, 1'b1);
    end
    step(1'b0, 1'b0, 1'b1, a_lvl, 1'b1);
    chk("cont_valid_drop", valid8, 1'b0);
    chk("cont_busy", busy8, 1'b1);
    chk("cont_count_held", count8, 8'd3);
    for (int k = 0; k < WIN; k++) begin
      if (k == 5 || k == 15) a_lvl = ~a_lvl;
      step(1'b0, 1'b0, 1'b0, a_lvl, 1'b0);
    end
    chk("cont_valid", valid8, 1'b1);
    chk("cont_count", count8, 8'd2);
    step(1'b0, 1'b0, 1'b0, a_lvl, 1'b1);
    chk("cont_idle", busy8, 1'b0);

    // Reset mid-window after 4 pulses, restart right after release
    step(1'b0, 1'b1, 1'b0, a_lvl, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) a_lvl = ~a_lvl;
      step(1'b0, 1'b0, 1'b0, a_lvl, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, a_lvl, 1'b0);
    chk("abort_valid", valid8, 1'b0);
    chk("abort_count", count8, 8'd0);
    chk("abort_busy", busy8, 1'b0);
    step(1'b0, 1'b1, 1'b0, a_lvl, 1'b0);
    chk("abort_restart", busy8, 1'b1);
    for (int k = 0; k < WIN; k++) step(1'b0, 1'b0, 1'b0, a_lvl, 1'b0);
    chk("abort_next_valid", valid8, 1'b1);
    chk("abort_next_count", count8, 8'd0);
    step(1'b0, 1'b0, 1'b0, a_lvl, 1'b1);

    // Reset and start together: reset wins
    step(1'b1, 1'b1, 1'b0, a_lvl, 1'b0);
    chk("rst_start_busy", busy8, 1'b0);

`ifdef SFQ_ZERO_CHECK_EN
    // Sticky zero-check error across windows until reset
    chk("err_clear", err8, 1'b0);
    ez = 1'b1;
    step(1'b0, 1'b1, 1'b0, a_lvl, 1'b0);
    for (int k = 0; k < WIN; k++) begin
      if (k == 3) a_lvl = ~a_lvl;
      step(1'b0, 1'b0, 1'b0, a_lvl, 1'b0);
      if (k == 3) chk("err_set", err8, 1'b1);
    end
    chk("err_count", count8, 8'd1);
    ez = 1'b0;
    step(1'b0, 1'b0, 1'b1, a_lvl, 1'b1);
    for (int k = 0; k < WIN; k++) step(1'b0, 1'b0, 1'b0, a_lvl, 1'b0);
    chk("err_sticky", err8, 1'b1);
    step(1'b1, 1'b0, 1'b0, a_lvl, 1'b0);
    chk("err_rst", err8, 1'b0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, s, c, rd;
      r  = ($urandom_range(63) == 0);
      s  = ($urandom_range(3) == 0);
      c  = ($urandom_range(1) == 1);
      rd = ($urandom_range(2) == 0);
      ez = ($urandom_range(15) == 0);
      if ($urandom_range(1) == 1) a_lvl = ~a_lvl;
      step(r, s, c, a_lvl, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
